// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage ARM pipeline.
// Decodes the latched instruction, evaluates its condition field against the
// status flags, reads a 15-entry register file (written back from WB on the
// falling clock edge) and registers everything into the ID/EXE register.
// Optional build macro REG_BYPASS_EN: a read that matches the WB destination
// while a write-back is active returns WB_Value in the same cycle.
module id_stage #(
   parameter int DW   = 32,
   parameter int NREG = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          flush,
   input  logic          hazard,
   input  logic [DW-1:0] PC_in,
   input  logic [31:0]   Instruction,
   input  logic [3:0]    SR,
   input  logic          WB_EN_in,
   input  logic [3:0]    WB_Dest,
   input  logic [DW-1:0] WB_Value,
   output logic [DW-1:0] PC,
   output logic          WB_EN,
   output logic          MEM_R_EN,
   output logic          MEM_W_EN,
   output logic          B,
   output logic          S,
   output logic [3:0]    EXE_CMD,
   output logic [DW-1:0] Val_Rn,
   output logic [DW-1:0] Val_Rm,
   output logic          imm,
   output logic [11:0]   Shift_operand,
   output logic [23:0]   Signed_imm_24,
   output logic [3:0]    Dest,
   output logic [3:0]    src1,
   output logic [3:0]    src2,
   output logic          Two_src
);

   // Index 15 is the PC slot: never stored, reads as zero, writes dropped.
   localparam logic [3:0] PC_IDX = 4'hF;

   // Instruction fields
   logic [3:0] cond, opcode, rn, rd, rm;
   logic [1:0] mode;
   logic       i_bit, s_bit;

   assign cond   = Instruction[31:28];
   assign mode   = Instruction[27:26];
   assign i_bit  = Instruction[25];
   assign opcode = Instruction[24:21];
   assign s_bit  = Instruction[20];
   assign rn     = Instruction[19:16];
   assign rd     = Instruction[15:12];
   assign rm     = Instruction[3:0];

   // Decoded (ungated) controls
   logic [3:0] exe_cmd_d;
   logic       wb_d, mr_d, mw_d, b_d, s_d;
   logic       cond_pass, issue;
   logic [DW-1:0] val_rn_d, val_rm_d;

   logic [DW-1:0] rf [NREG];

   // Condition field against {N,Z,C,V}
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'h0: cond_pass = SR[2];
         4'h1: cond_pass = ~SR[2];
         4'h2: cond_pass = SR[1];
         4'h3: cond_pass = ~SR[1];
         4'h4: cond_pass = SR[3];
         4'h5: cond_pass = ~SR[3];
         4'h6: cond_pass = SR[0];
         4'h7: cond_pass = ~SR[0];
         4'h8: cond_pass = SR[1] & ~SR[2];
         4'h9: cond_pass = ~SR[1] | SR[2];
         4'hA: cond_pass = (SR[3] == SR[0]);
         4'hB: cond_pass = (SR[3] != SR[0]);
         4'hC: cond_pass = ~SR[2] & (SR[3] == SR[0]);
         4'hD: cond_pass = SR[2] | (SR[3] != SR[0]);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Control decode by mode and opcode. S passes through for data-processing
   // and memory forms (load/store bit in the latter); branch and mode 11 clear it.
   always_comb begin
      exe_cmd_d = 4'b0000;
      wb_d      = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
      b_d       = 1'b0;
      s_d       = 1'b0;
      case (mode)
         2'b00: begin
            s_d  = s_bit;
            wb_d = 1'b1;
            case (opcode)
               4'b1101: exe_cmd_d = 4'b0001;
               4'b1111: exe_cmd_d = 4'b1001;
               4'b0100: exe_cmd_d = 4'b0010;
               4'b0101: exe_cmd_d = 4'b0011;
               4'b0010: exe_cmd_d = 4'b0100;
               4'b0110: exe_cmd_d = 4'b0101;
               4'b0000: exe_cmd_d = 4'b0110;
               4'b1100: exe_cmd_d = 4'b0111;
               4'b0001: exe_cmd_d = 4'b1000;
               4'b1010: begin exe_cmd_d = 4'b0100; wb_d = 1'b0; end
               4'b1000: begin exe_cmd_d = 4'b0110; wb_d = 1'b0; end
               default: begin exe_cmd_d = 4'b0000; wb_d = 1'b0; end
            endcase
         end
         2'b01: begin
            exe_cmd_d = 4'b0010;
            s_d       = s_bit;
            if (s_bit) begin
               mr_d = 1'b1;
               wb_d = 1'b1;
            end else begin
               mw_d = 1'b1;
            end
         end
         2'b10: b_d = 1'b1;
         default: ;
      endcase
   end

   // A failed condition or a hazard squashes the side-effecting controls only.
   assign issue = cond_pass & ~hazard;

   // Stores read Rd as their second operand (the data to store).
   assign src1    = rn;
   assign src2    = mw_d ? rd : rm;
   assign Two_src = ~i_bit | mw_d;

   // Register file write-back on the falling edge; reset reloads R[i]=i.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= DW'(i);
      end else if (WB_EN_in && (WB_Dest != PC_IDX)) begin
         rf[WB_Dest] <= WB_Value;
      end
   end

   // First operand read (Rn)
   always_comb begin
      val_rn_d = '0;
      if (src1 != PC_IDX) val_rn_d = rf[src1];
`ifdef REG_BYPASS_EN
      if (WB_EN_in && (WB_Dest == src1) && (src1 != PC_IDX)) val_rn_d = WB_Value;
`endif
   end

   // Second operand read (Rm, or Rd for stores)
   always_comb begin
      val_rm_d = '0;
      if (src2 != PC_IDX) val_rm_d = rf[src2];
`ifdef REG_BYPASS_EN
      if (WB_EN_in && (WB_Dest == src2) && (src2 != PC_IDX)) val_rm_d = WB_Value;
`endif
   end

   // ID/EXE register: reset, then flush, then freeze, then load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         PC            <= '0;
         WB_EN         <= 1'b0;
         MEM_R_EN      <= 1'b0;
         MEM_W_EN      <= 1'b0;
         B             <= 1'b0;
         S             <= 1'b0;
         EXE_CMD       <= 4'b0000;
         Val_Rn        <= '0;
         Val_Rm        <= '0;
         imm           <= 1'b0;
         Shift_operand <= 12'h000;
         Signed_imm_24 <= 24'h000000;
         Dest          <= 4'h0;
      end else if (!freeze) begin
         PC            <= PC_in;
         WB_EN         <= wb_d & issue;
         MEM_R_EN      <= mr_d & issue;
         MEM_W_EN      <= mw_d & issue;
         B             <= b_d & issue;
         S             <= s_d & issue;
         EXE_CMD       <= exe_cmd_d;
         Val_Rn        <= val_rn_d;
         Val_Rm        <= val_rm_d;
         imm           <= i_bit;
         Shift_operand <= Instruction[11:0];
         Signed_imm_24 <= Instruction[23:0];
         Dest          <= rd;
      end
   end

endmodule
